// File: rtl/if_pkg.sv
// Shared types for the instruction fetch unit: redirect source select and fetch-queue entry.
package if_pkg;

   localparam int unsigned IF_XLEN = 32;

   typedef enum logic [1:0] {
      SEL_BRANCH = 2'd0,
      SEL_JAL    = 2'd1,
      SEL_JALR   = 2'd2,
      SEL_SEQ    = 2'd3
   } redir_sel_t;

   typedef struct packed {
      logic [IF_XLEN-1:0] instr;
      logic [IF_XLEN-1:0] pc;
   } fq_entry_t;

   // Fixed priority: branch over jal over jalr; SEL_SEQ when no redirect is requested.
   function automatic redir_sel_t redir_select(input logic i_branch,
                                               input logic i_jal,
                                               input logic i_jalr);
      redir_sel_t sel;
      sel = SEL_SEQ;
      if (i_branch) begin
         sel = SEL_BRANCH;
      end else if (i_jal) begin
         sel = SEL_JAL;
      end else if (i_jalr) begin
         sel = SEL_JALR;
      end
      return sel;
   endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Circular fetch queue of {instr, pc} entries with push, pop, flush and occupancy count.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned FQ_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_flush,
   input  logic                      i_push,
   input  fq_entry_t                 i_push_entry,
   input  logic                      i_pop,
   output fq_entry_t                 o_head,
   output logic [$clog2(FQ_DEPTH):0] o_count
);

   localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  r_instr [FQ_DEPTH];
   logic [XLEN-1:0]  r_pc    [FQ_DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Flush wins over everything; push/pop are also guarded against full/empty.
   assign w_push = i_push && !i_flush && (r_count != CNT_W'(FQ_DEPTH));
   assign w_pop  = i_pop  && !i_flush && (r_count != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr[r_tail] <= XLEN'(i_push_entry.instr);
         r_pc[r_tail]    <= XLEN'(i_push_entry.pc);
      end
   end

   assign o_head.instr = IF_XLEN'(r_instr[r_head]);
   assign o_head.pc    = IF_XLEN'(r_pc[r_head]);
   assign o_count      = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch control: sequential PC, redirects, one outstanding imem request, fetch queue.
// Define IF_FETCH_PERF_EN to add the perf_fetched / perf_flushed event counters.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int unsigned     XLEN     = IF_XLEN,
   parameter int unsigned     FQ_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            branch,
   input  logic            jal,
   input  logic            jalr,
   input  logic [XLEN-1:0] branch_addr,
   input  logic [XLEN-1:0] jal_addr,
   input  logic [XLEN-1:0] jalr_addr,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_instr,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_flushed,
`endif
   output logic [XLEN-1:0] dec_pc
);

   localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_pending_pc;
   logic             r_outstanding;
   logic             r_dropped;

   logic             w_redirect;
   redir_sel_t       w_sel;
   logic [XLEN-1:0]  w_target;
   logic             w_issue;
   logic             w_rsp;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_count;
   fq_entry_t        w_head;
   fq_entry_t        w_push_entry;

   assign w_redirect = branch || jal || jalr;
   assign w_sel      = redir_select(branch, jal, jalr);

   always_comb begin
      w_target = r_fetch_pc;
      case (w_sel)
         SEL_BRANCH: w_target = branch_addr;
         SEL_JAL:    w_target = jal_addr;
         SEL_JALR:   w_target = jalr_addr;
         default:    w_target = r_fetch_pc;
      endcase
   end

   // A response only counts when one is outstanding; dropped or redirect-cycle responses are discarded.
   assign w_rsp   = imem_rvalid && r_outstanding;
   assign w_push  = w_rsp && !r_dropped && !w_redirect;
   assign w_issue = !reset && !w_redirect && !r_outstanding && (w_count < CNT_W'(FQ_DEPTH));
   assign w_pop   = dec_valid && dec_ready && !w_redirect;

   assign w_push_entry.instr = IF_XLEN'(imem_rdata);
   assign w_push_entry.pc    = IF_XLEN'(r_pending_pc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_pending_pc  <= '0;
         r_outstanding <= 1'b0;
         r_dropped     <= 1'b0;
      end else begin
         if (w_redirect) begin
            r_fetch_pc <= w_target;
         end else if (w_issue) begin
            r_fetch_pc   <= r_fetch_pc + XLEN'(4);
            r_pending_pc <= r_fetch_pc;
         end
         if (w_rsp) begin
            r_outstanding <= 1'b0;
            r_dropped     <= 1'b0;
         end else if (w_issue) begin
            r_outstanding <= 1'b1;
         end else if (w_redirect && r_outstanding) begin
            r_dropped <= 1'b1;
         end
      end
   end

   if_fetch_queue #(
      .XLEN     (XLEN),
      .FQ_DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .i_flush      (w_redirect),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_count      (w_count)
   );

   assign imem_req  = w_issue;
   assign imem_addr = r_fetch_pc;
   assign dec_valid = (w_count != '0);
   assign dec_instr = XLEN'(w_head.instr);
   assign dec_pc    = XLEN'(w_head.pc);

`ifdef IF_FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_fetched <= '0;
         r_perf_flushed <= '0;
      end else begin
         if (w_push) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (w_redirect) begin
            r_perf_flushed <= r_perf_flushed + 32'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a programmable-latency instruction memory.
`timescale 1ns/1ps
module tb_if_fetch_unit;

   localparam logic [31:0] KEY = 32'h1300_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        branch, jal, jalr;
   logic [31:0] branch_addr, jal_addr, jalr_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dec_valid, dec_ready;
   logic [31:0] dec_instr, dec_pc;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed;
`endif

   int total = 0;
   int bad   = 0;

   int          mem_lat = 1;
   logic        spur    = 1'b0;
   logic        m_pend  = 1'b0;
   int          m_cnt   = 0;
   logic [31:0] m_addr  = '0;

   logic [31:0] req_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_instr_q[$];

   always #5 clk = ~clk;

   if_fetch_unit #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .reset       (reset),
      .branch      (branch),
      .jal         (jal),
      .jalr        (jalr),
      .branch_addr (branch_addr),
      .jal_addr    (jal_addr),
      .jalr_addr   (jalr_addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_instr   (dec_instr),
`ifdef IF_FETCH_PERF_EN
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed),
`endif
      .dec_pc      (dec_pc)
   );

   // Memory: responds mem_lat cycles after a request with instr = addr ^ KEY.
   assign imem_rvalid = (m_pend && m_cnt == 0) || spur;
   assign imem_rdata  = m_addr ^ KEY;

   always @(posedge clk) begin
      if (reset) begin
         m_pend <= 1'b0;
      end else if (imem_req) begin
         m_pend <= 1'b1;
         m_cnt  <= mem_lat - 1;
         m_addr <= imem_addr;
      end else if (m_pend && m_cnt == 0) begin
         m_pend <= 1'b0;
      end else if (m_pend) begin
         m_cnt <= m_cnt - 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      #1;
      if (imem_req) req_q.push_back(imem_addr);
      if (dec_valid && dec_ready) begin
         pop_pc_q.push_back(dec_pc);
         pop_instr_q.push_back(dec_instr);
      end
      @(negedge clk);
   endtask

   task automatic clear_logs();
      req_q.delete();
      pop_pc_q.delete();
      pop_instr_q.delete();
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      branch = 1'b0;
      jal    = 1'b0;
      jalr   = 1'b0;
      step();
      step();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (imem_req !== 1'b0) begin
         bad++; $display("FAIL reset_req: got %b want 0", imem_req);
      end
      total++;
      if (dec_valid !== 1'b0) begin
         bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_sequential();
      mem_lat   = 1;
      dec_ready = 1'b1;
      do_reset();
      step();
      total++;
      if (req_q.size() != 1 || req_q[0] !== 32'h0) begin
         bad++; $display("FAIL seq_first_req: got n=%0d addr=%h want n=1 addr=0", req_q.size(), req_q[0]);
      end
      repeat (16) step();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (req_q[i] !== 32'(4 * i)) begin
            bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, req_q[i], 32'(4 * i));
         end
         total++;
         if (pop_pc_q[i] !== 32'(4 * i)) begin
            bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pop_pc_q[i], 32'(4 * i));
         end
         total++;
         if (pop_instr_q[i] !== (32'(4 * i) ^ KEY)) begin
            bad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, pop_instr_q[i], 32'(4 * i) ^ KEY);
         end
      end
   endtask

   task automatic test_backpressure();
      mem_lat   = 1;
      dec_ready = 1'b0;
      do_reset();
      repeat (30) step();
      total++;
      if (req_q.size() != 4) begin
         bad++; $display("FAIL bp_req_count: got %0d want 4", req_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (req_q[i] !== 32'(4 * i)) begin
            bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, req_q[i], 32'(4 * i));
         end
      end
      #1;
      total++;
      if (imem_req !== 1'b0 || dec_valid !== 1'b1) begin
         bad++; $display("FAIL bp_full_state: got req=%b valid=%b want req=0 valid=1", imem_req, dec_valid);
      end
      total++;
      if (dec_pc !== 32'h0 || dec_instr !== KEY) begin
         bad++; $display("FAIL bp_head: got pc=%h instr=%h want pc=0 instr=%h", dec_pc, dec_instr, KEY);
      end
      @(negedge clk);
      spur = 1'b1;
      step();
      spur = 1'b0;
      dec_ready = 1'b1;
      clear_logs();
      step();
      total++;
      if (req_q.size() != 0) begin
         bad++; $display("FAIL bp_no_req_while_full: got %0d reqs want 0", req_q.size());
      end
      step();
      total++;
      if (req_q.size() != 1 || req_q[0] !== 32'h10) begin
         bad++; $display("FAIL bp_resume: got n=%0d addr=%h want n=1 addr=10", req_q.size(), req_q[0]);
      end
      repeat (18) step();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (pop_pc_q[i] !== 32'(4 * i)) begin
            bad++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, pop_pc_q[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_priority();
      mem_lat   = 1;
      dec_ready = 1'b0;
      do_reset();
      repeat (30) step();
      branch = 1'b1; jal = 1'b1; jalr = 1'b1;
      branch_addr = 32'h40; jal_addr = 32'h80; jalr_addr = 32'hC0;
      dec_ready = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0) begin
         bad++; $display("FAIL prio_req_in_redirect: got %b want 0", imem_req);
      end
      @(negedge clk);
      branch = 1'b0; jal = 1'b0; jalr = 1'b0;
      #1;
      total++;
      if (dec_valid !== 1'b0) begin
         bad++; $display("FAIL prio_flushed: got dec_valid=%b want 0", dec_valid);
      end
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         bad++; $display("FAIL prio_branch_target: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr);
      end
      @(negedge clk);
      jal = 1'b1; jalr = 1'b1;
      #1;
      @(negedge clk);
      jal = 1'b0; jalr = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80 || dec_valid !== 1'b0) begin
         bad++; $display("FAIL prio_jal_over_jalr: got req=%b addr=%h valid=%b want 1/80/0", imem_req, imem_addr, dec_valid);
      end
      @(negedge clk);
      clear_logs();
      repeat (10) step();
      total++;
      if (pop_pc_q[0] !== 32'h80) begin
         bad++; $display("FAIL prio_first_pop: got %h want 80", pop_pc_q[0]);
      end
   endtask

   task automatic test_drop();
      bit found;
      found     = 1'b0;
      mem_lat   = 3;
      dec_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 60 && !found; k++) begin
         step();
         if (req_q.size() > 0 && req_q[req_q.size() - 1] == 32'hC) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL drop_wait_req_c: got no request to C want one within 60 cycles");
      end
      jalr = 1'b1; jalr_addr = 32'h100;
      #1;
      @(negedge clk);
      jalr = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
         bad++; $display("FAIL drop_wait_state: got req=%b valid=%b want 0/0", imem_req, dec_valid);
      end
      @(negedge clk);
      clear_logs();
      repeat (20) step();
      total++;
      if (req_q[0] !== 32'h100) begin
         bad++; $display("FAIL drop_first_req: got %h want 100", req_q[0]);
      end
      total++;
      if (pop_pc_q[0] !== 32'h100 || pop_instr_q[0] !== (32'h100 ^ KEY)) begin
         bad++; $display("FAIL drop_first_pop: got pc=%h instr=%h want pc=100 instr=%h", pop_pc_q[0], pop_instr_q[0], 32'h100 ^ KEY);
      end
      mem_lat = 1;
   endtask

   task automatic test_reset_mid();
      mem_lat   = 1;
      dec_ready = 1'b0;
      do_reset();
      repeat (6) step();
      #1;
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
         bad++; $display("FAIL rst_mid_pre: got valid=%b pc=%h want 1/0", dec_valid, dec_pc);
      end
      reset = 1'b1;
      #1;
      total++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
         bad++; $display("FAIL rst_mid_async: got valid=%b req=%b want 0/0", dec_valid, imem_req);
      end
      @(negedge clk);
      step();
      reset = 1'b0;
      dec_ready = 1'b1;
      clear_logs();
      step();
      total++;
      if (req_q.size() != 1 || req_q[0] !== 32'h0) begin
         bad++; $display("FAIL rst_mid_first_req: got n=%0d addr=%h want n=1 addr=0", req_q.size(), req_q[0]);
      end
      repeat (10) step();
      total++;
      if (pop_pc_q[0] !== 32'h0 || pop_instr_q[0] !== KEY || pop_pc_q[1] !== 32'h4) begin
         bad++; $display("FAIL rst_mid_pops: got %h/%h/%h want 0/%h/4", pop_pc_q[0], pop_instr_q[0], pop_pc_q[1], KEY);
      end
   endtask

   task automatic test_wrap();
      mem_lat   = 1;
      dec_ready = 1'b0;
      do_reset();
      repeat (30) step();
      jal = 1'b1; jal_addr = 32'hFFFF_FFFC;
      step();
      jal = 1'b0;
      dec_ready = 1'b1;
      clear_logs();
      repeat (12) step();
      total++;
      if (req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h0) begin
         bad++; $display("FAIL wrap_addr: got %h,%h want FFFFFFFC,0", req_q[0], req_q[1]);
      end
      total++;
      if (pop_pc_q[0] !== 32'hFFFF_FFFC || pop_pc_q[1] !== 32'h0 || pop_instr_q[1] !== KEY) begin
         bad++; $display("FAIL wrap_pop: got %h,%h,%h want FFFFFFFC,0,%h", pop_pc_q[0], pop_pc_q[1], pop_instr_q[1], KEY);
      end
   endtask

   initial begin
      reset       = 1'b1;
      branch      = 1'b0;
      jal         = 1'b0;
      jalr        = 1'b0;
      branch_addr = '0;
      jal_addr    = '0;
      jalr_addr   = '0;
      dec_ready   = 1'b0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_backpressure();
      test_priority();
      test_drop();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 The block SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries, power of two, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-004 The block SHALL have these ports, one per line:
 clk  in  1  clock, rising edge.
 reset  in  1  asynchronous, active-high.
 branch, jal, jalr  in  1 each  redirect requests.
 branch_addr, jal_addr, jalr_addr  in  XLEN each  redirect targets.
 imem_req  out  1  fetch request.
 imem_addr  out  XLEN  fetch address.
 imem_rvalid  in  1  response valid.
 imem_rdata  in  XLEN  response instruction.
 dec_valid  out  1  queue head valid.
 dec_ready  in  1  decode accepts.
 dec_instr  out  XLEN  head instruction.
 dec_pc  out  XLEN  head PC.

Function
REQ-005 Redirect priority SHALL be branch > jal > jalr; redirect = any of the three high.
REQ-006 imem_req SHALL be high when no redirect, no outstanding request and (queue count + 0) < FQ_DEPTH; imem_addr = fetch_pc.
REQ-007 At most one request SHALL be outstanding; the response arrives one or more cycles after imem_req, in order.
REQ-008 On issuing a request, fetch_pc SHALL advance by 4 (mod 2^XLEN wrap-around) and the issued address SHALL be held as the pending PC.
REQ-009 A non-dropped imem_rvalid SHALL push {imem_rdata, pending PC} at the tail; a request is issued only when a slot is reserved, so overflow is impossible.
REQ-010 dec_valid SHALL equal (count != 0); dec_instr/dec_pc SHALL show the head entry combinationally from registers; dec_valid && dec_ready pops the head.
REQ-011 Push and pop in the same cycle SHALL leave count unchanged; full with a pop allows a new request the next cycle.
REQ-012 Head/tail pointers SHALL wrap modulo FQ_DEPTH; count SHALL range 0..FQ_DEPTH.
REQ-013 Redirect SHALL, at the next edge, empty the queue, set fetch_pc to the selected target and mark any outstanding response as dropped; dec_valid is low in the following cycle.
REQ-014 A response arriving in the same cycle as a redirect, or marked dropped, SHALL be discarded and SHALL clear the outstanding state.
REQ-015 A pop in the redirect cycle SHALL be ignored beyond the flush; no request is issued in the redirect cycle.
REQ-016 First fetch after a redirect SHALL be issued in the cycle after the redirect, to the target address.
REQ-017 imem_rvalid with no outstanding request SHALL be ignored.

Reset
REQ-018 While reset is high: imem_req=0, dec_valid=0, count=0, pointers=0, outstanding=0, dropped=0, fetch_pc=RESET_PC.
REQ-019 Reset mid-operation SHALL discard queue contents and any in-flight response; first request goes to RESET_PC in the first cycle after release.

Configuration
REQ-020 With IF_FETCH_PERF_EN defined, the block SHALL add outputs perf_fetched (32-bit, +1 per accepted push) and perf_flushed (32-bit, +1 per redirect), both wrapping and reset to 0.
REQ-021 Without IF_FETCH_PERF_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-022 Package if_pkg SHALL hold the redirect-select enum (SEL_BRANCH, SEL_JAL, SEL_JALR, SEL_SEQ) and the fetch-queue entry struct {instr, pc}.
REQ-023 The queue SHALL be a sub-module if_fetch_queue (parametrised by XLEN, FQ_DEPTH) with push/pop/flush/count; the fetch control stays in if_fetch_unit.

Verification
REQ-024 Reset release, 1-cycle memory, dec_ready=1 -> imem_addr 0,4,8,... and dec_pc 0,4,8 in order with matching instructions.
REQ-025 dec_ready=0 with FQ_DEPTH=4 -> exactly 4 entries buffered, imem_req stays low, dec_valid stays high; dec_ready=1 -> drains PC 0,4,8,C then fetch resumes at 10.
REQ-026 branch=1, jal=1 with branch_addr=40, jal_addr=80 -> next imem_addr 40, queue empty next cycle.
REQ-027 Redirect to 100 while a request to C is outstanding, response arrives 2 cycles later -> that response dropped, first dec_pc is 100.
REQ-028 Reset asserted with queue holding 3 entries -> dec_valid=0 immediately, first fetch after release to RESET_PC.
REQ-029 fetch_pc=FFFFFFFC, XLEN=32 -> next imem_addr 0 (wrap).
